// File: rtl/pipe_mac_if.sv
// Sample/result bundle for pipe_mac: the source drives operands and tags, the MAC
// returns the qualified result and its overflow flag.
interface pipe_mac_if #(
  parameter int DW = 8,
  parameter int GW = 4
);
  localparam int OW = 2*DW + GW;

  logic          in_valid;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] c;
  logic          mode;
  logic          clr;
  logic          out_valid;
  logic [OW-1:0] g;
  logic          ovf;

  modport master (
    output in_valid, a, b, c, mode, clr,
    input  out_valid, g, ovf
  );

  modport slave (
    input  in_valid, a, b, c, mode, clr,
    output out_valid, g, ovf
  );
endinterface

// File: rtl/pipe_mac.sv
// 4-stage pipelined multiply-add / multiply-accumulate with valid tagging.
// Optional build macro MAC_SAT_EN: saturate g/acc to all-ones on overflow and flag ovf.
module pipe_mac #(
  parameter int          DW     = 8,
  parameter int          GW     = 4,
  parameter int unsigned OFFSET = 78
) (
  input  logic      clk,
  input  logic      reset,
  pipe_mac_if.slave bus
);
  localparam int OW = 2*DW + GW;
  localparam int PW = 2*DW;

  // S1: captured sample
  logic [DW-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
  logic          s1_mode_q, s1_mode_d, s1_clr_q, s1_clr_d, s1_vld_q, s1_vld_d;
  // S2: product
  logic [PW-1:0] s2_p_q, s2_p_d;
  logic [DW-1:0] s2_c_q, s2_c_d;
  logic          s2_mode_q, s2_mode_d, s2_clr_q, s2_clr_d, s2_vld_q, s2_vld_d;
  // S3: operands of the final add
  logic [PW-1:0] s3_p_q, s3_p_d;
  logic [DW-1:0] s3_c_q, s3_c_d;
  logic          s3_mode_q, s3_mode_d, s3_clr_q, s3_clr_d, s3_vld_q, s3_vld_d;
  // S4: accumulator and output register
  logic [OW-1:0] acc_q, acc_d, g_q, g_d;
  logic          ovf_q, ovf_d, out_valid_q, out_valid_d;

  logic [OW-1:0] addend_t;
  logic [OW-1:0] res;
  logic          res_ovf;
`ifdef MAC_SAT_EN
  logic [OW:0]   sum;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    s1_a_d    = s1_a_q;
    s1_b_d    = s1_b_q;
    s1_c_d    = s1_c_q;
    s1_mode_d = s1_mode_q;
    if (bus.in_valid) begin
      s1_a_d    = bus.a;
      s1_b_d    = bus.b;
      s1_c_d    = bus.c;
      s1_mode_d = bus.mode;
    end
    s1_clr_d = bus.clr;
    s1_vld_d = bus.in_valid;

    s2_p_d    = PW'(s1_a_q) * PW'(s1_b_q);
    s2_c_d    = s1_c_q;
    s2_mode_d = s1_mode_q;
    s2_clr_d  = s1_clr_q;
    s2_vld_d  = s1_vld_q;

    // Pure forwarding stage: gives the multiplier a full cycle before the adder.
    s3_p_d    = s2_p_q;
    s3_c_d    = s2_c_q;
    s3_mode_d = s2_mode_q;
    s3_clr_d  = s2_clr_q;
    s3_vld_d  = s2_vld_q;
  end

  always_comb begin
    if (!s3_mode_q)    addend_t = OW'(OFFSET);
    else if (s3_clr_q) addend_t = '0;
    else               addend_t = acc_q;

`ifdef MAC_SAT_EN
    sum     = (OW+1)'(s3_p_q) + (OW+1)'(s3_c_q) + (OW+1)'(addend_t);
    res_ovf = sum[OW];
    res     = sum[OW] ? {OW{1'b1}} : sum[OW-1:0];
`else
    res_ovf = 1'b0;
    res     = OW'(s3_p_q) + OW'(s3_c_q) + addend_t;
`endif

    // acc feeds back into this same stage, so a back-to-back accumulate sees the fresh value.
    acc_d = acc_q;
    if (s3_vld_q && s3_mode_q)      acc_d = res;
    else if (!s3_vld_q && s3_clr_q) acc_d = '0;

    g_d         = g_q;
    ovf_d       = 1'b0;
    out_valid_d = s3_vld_q;
    if (s3_vld_q) begin
      g_d   = res;
      ovf_d = res_ovf;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s1_mode_q   <= 1'b0;
      s1_clr_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      s2_p_q      <= '0;
      s2_c_q      <= '0;
      s2_mode_q   <= 1'b0;
      s2_clr_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_p_q      <= '0;
      s3_c_q      <= '0;
      s3_mode_q   <= 1'b0;
      s3_clr_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      acc_q       <= '0;
      g_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      s1_mode_q   <= s1_mode_d;
      s1_clr_q    <= s1_clr_d;
      s1_vld_q    <= s1_vld_d;
      s2_p_q      <= s2_p_d;
      s2_c_q      <= s2_c_d;
      s2_mode_q   <= s2_mode_d;
      s2_clr_q    <= s2_clr_d;
      s2_vld_q    <= s2_vld_d;
      s3_p_q      <= s3_p_d;
      s3_c_q      <= s3_c_d;
      s3_mode_q   <= s3_mode_d;
      s3_clr_q    <= s3_clr_d;
      s3_vld_q    <= s3_vld_d;
      acc_q       <= acc_d;
      g_q         <= g_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.g         = g_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_mac.sv
// Self-checking bench for pipe_mac: directed scenarios plus random traffic, all scored
// against an arithmetic model that predicts each result at issue time.
module tb_pipe_mac;
  localparam int     DW   = 8;
  localparam int     GW   = 4;
  localparam int     OW   = 2*DW + GW;
  localparam longint FULL = longint'(1) << OW;

  typedef struct {
    int     cyc;
    longint g;
    bit     ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_mac_if #(.DW(DW), .GW(GW)) bus ();

  pipe_mac #(.DW(DW), .GW(GW), .OFFSET(78)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     checks = 0;
  int     errors = 0;
  int     cyc    = 0;
  exp_t   expq[$];
  exp_t   e;
  longint acc_m  = 0;
  longint last_g = 0;
  bit     mon_en = 1'b0;

  logic [OW-1:0] h_g [0:4095];
  bit            h_v [0:4095];
  bit            h_o [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drive one cycle of input; the model computes the result straight from the arithmetic rules.
  task automatic issue(input bit v, input int a, input int b, input int c, input bit m, input bit clr);
    longint t, s, r;
    bit     o;
    bus.in_valid = v;
    bus.a        = DW'(a);
    bus.b        = DW'(b);
    bus.c        = DW'(c);
    bus.mode     = m;
    bus.clr      = clr;
    if (v) begin
      t = (m == 1'b0) ? 78 : (clr ? 0 : acc_m);
      s = longint'(a) * longint'(b) + longint'(c) + t;
`ifdef MAC_SAT_EN
      if (s >= FULL) begin r = FULL - 1; o = 1'b1; end
      else           begin r = s;        o = 1'b0; end
`else
      r = s % FULL;
      o = 1'b0;
`endif
      if (m) acc_m = r;
      expq.push_back('{cyc: cyc + 4, g: r, ovf: o});
    end else if (clr) begin
      acc_m = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      h_g[cyc % 4096] = bus.g;
      h_v[cyc % 4096] = bus.out_valid;
      h_o[cyc % 4096] = bus.ovf;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        check("out_valid", 64'(bus.out_valid), 64'(1));
        check("g", 64'(bus.g), 64'(e.g));
        check("ovf", 64'(bus.ovf), 64'(e.ovf));
        last_g = e.g;
      end else begin
        check("idle_valid", 64'(bus.out_valid), 64'(0));
        check("idle_ovf", 64'(bus.ovf), 64'(0));
        check("hold_g", 64'(bus.g), 64'(last_g));
      end
    end
  end

  function automatic int hi(input int k);
    return k % 4096;
  endfunction

  initial begin
    int base, b2;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.c        = '0;
    bus.mode     = 1'b0;
    bus.clr      = 1'b0;

    #12;
    check("reset_g", 64'(bus.g), 64'(0));
    check("reset_valid", 64'(bus.out_valid), 64'(0));
    check("reset_ovf", 64'(bus.ovf), 64'(0));
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Single multiply-add sample
    base = cyc;
    issue(1'b1, 3, 4, 5, 1'b0, 1'b0);
    idle(6);
    check("single_v3", 64'(h_v[hi(base+3)]), 64'(0));
    check("single_v4", 64'(h_v[hi(base+4)]), 64'(1));
    check("single_g", 64'(h_g[hi(base+4)]), 64'h5F);
    check("single_ovf", 64'(h_o[hi(base+4)]), 64'(0));
    check("single_v5", 64'(h_v[hi(base+5)]), 64'(0));

    // Back-to-back multiply-add, then a bubble
    base = cyc;
    issue(1'b1, 1, 1, 0, 1'b0, 1'b0);
    issue(1'b1, 2, 2, 0, 1'b0, 1'b0);
    issue(1'b1, 255, 255, 255, 1'b0, 1'b0);
    idle(6);
    check("b2b_g0", 64'(h_g[hi(base+4)]), 64'(79));
    check("b2b_g1", 64'(h_g[hi(base+5)]), 64'(82));
    check("b2b_g2", 64'(h_g[hi(base+6)]), 64'(65358));
    check("b2b_bubble_v", 64'(h_v[hi(base+7)]), 64'(0));
    check("b2b_bubble_g", 64'(h_g[hi(base+7)]), 64'(65358));

    // Accumulate run with an interleaved mode-0 sample and a standalone clear
    base = cyc;
    issue(1'b1, 2, 3, 1, 1'b1, 1'b1);
    issue(1'b1, 2, 3, 1, 1'b1, 1'b0);
    issue(1'b1, 2, 3, 1, 1'b1, 1'b0);
    issue(1'b1, 1, 1, 0, 1'b0, 1'b0);
    issue(1'b1, 0, 0, 0, 1'b1, 1'b0);
    issue(1'b0, 0, 0, 0, 1'b0, 1'b1);
    issue(1'b1, 1, 1, 0, 1'b1, 1'b0);
    idle(6);
    check("acc_first", 64'(h_g[hi(base+4)]), 64'(7));
    check("acc_second", 64'(h_g[hi(base+5)]), 64'(14));
    check("acc_third", 64'(h_g[hi(base+6)]), 64'(21));
    check("acc_mode0", 64'(h_g[hi(base+7)]), 64'(79));
    check("acc_undisturbed", 64'(h_g[hi(base+8)]), 64'(21));
    check("acc_clr_bubble", 64'(h_v[hi(base+9)]), 64'(0));
    check("acc_after_clr", 64'(h_g[hi(base+10)]), 64'(1));

    // Accumulate past the top of the output range
    base = cyc;
    issue(1'b0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) issue(1'b1, 255, 255, 255, 1'b1, 1'b0);
    idle(6);
    check("sat_16_g", 64'(h_g[hi(base+20)]), 64'(1044480));
    check("sat_16_ovf", 64'(h_o[hi(base+20)]), 64'(0));
`ifdef MAC_SAT_EN
    check("sat_17_g", 64'(h_g[hi(base+21)]), 64'hFFFFF);
    check("sat_17_ovf", 64'(h_o[hi(base+21)]), 64'(1));
`else
    check("wrap_17_g", 64'(h_g[hi(base+21)]), 64'h0EF00);
    check("wrap_17_ovf", 64'(h_o[hi(base+21)]), 64'(0));
`endif

    // Reset while samples are in flight
    base = cyc;
    issue(1'b1, 10, 10, 10, 1'b1, 1'b0);
    issue(1'b1, 20, 20, 20, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_g", 64'(bus.g), 64'(0));
    check("midrst_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_ovf", 64'(bus.ovf), 64'(0));
    expq.delete();
    acc_m  = 0;
    last_g = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(6);
    for (int i = 3; i < 9; i++) check("postrst_quiet", 64'(h_v[hi(base+i)]), 64'(0));
    b2 = cyc;
    issue(1'b1, 1, 1, 0, 1'b1, 1'b0);
    idle(6);
    check("postrst_acc", 64'(h_g[hi(b2+4)]), 64'(1));
    check("postrst_v", 64'(h_v[hi(b2+4)]), 64'(1));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      issue(($urandom % 4) != 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 1'($urandom % 2), ($urandom % 8) == 0);
    end
    idle(6);
    check("queue_drained", 64'(expq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
